// File: rtl/cpu_alu_pkg.sv
// Shared definitions for the 8008-style ALU and its sequencer:
// opcodes, controller state encoding, flag indices and the captured-result record.
package cpu_alu_pkg;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_ADC = 3'b001;
    localparam logic [2:0] ALU_SUB = 3'b010;
    localparam logic [2:0] ALU_SBB = 3'b011;
    localparam logic [2:0] ALU_AND = 3'b100;
    localparam logic [2:0] ALU_XOR = 3'b101;
    localparam logic [2:0] ALU_OR  = 3'b110;
    localparam logic [2:0] ALU_CMP = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WB   = 2'd2
    } ctrl_state_e;

    localparam int FLAG_C = 0;
    localparam int FLAG_Z = 1;
    localparam int FLAG_S = 2;
    localparam int FLAG_P = 3;

    typedef struct packed {
        logic [7:0] e;
        logic       c;
        logic       z;
        logic       s;
        logic       p;
    } alu_res_t;

    // 1 when the byte holds an even number of ones
    function automatic logic even_par(input logic [7:0] v);
        return ~^v;
    endfunction

endpackage

// File: rtl/cpu_alu.sv
// Combinational 8008-style ALU. C_O is carry for ADD/ADC, borrow for SUB/SBB/CMP,
// and cleared for the logic ops.
module cpu_alu
    import cpu_alu_pkg::*;
(
    input  logic [7:0] X_I,
    input  logic [7:0] Y_I,
    input  logic [2:0] OP_I,
    input  logic       C_I,
    output logic [7:0] E_O,
    output logic       C_O,
    output logic       Z_O,
    output logic       S_O,
    output logic       P_O
);

    logic [8:0] sum;

    always_comb begin
        sum = '0;
        case (OP_I)
            ALU_ADD: sum = {1'b0, X_I} + {1'b0, Y_I};
            ALU_ADC: sum = {1'b0, X_I} + {1'b0, Y_I} + {8'b0, C_I};
            ALU_SUB,
            ALU_CMP: sum = {1'b0, X_I} - {1'b0, Y_I};
            ALU_SBB: sum = {1'b0, X_I} - {1'b0, Y_I} - {8'b0, C_I};
            ALU_AND: sum = {1'b0, X_I & Y_I};
            ALU_XOR: sum = {1'b0, X_I ^ Y_I};
            ALU_OR:  sum = {1'b0, X_I | Y_I};
            default: sum = '0;
        endcase
    end

    // 9-bit subtraction wraps, so bit 8 doubles as the borrow
    assign E_O = sum[7:0];
    assign C_O = sum[8];
    assign Z_O = (sum[7:0] == 8'h00);
    assign S_O = sum[7];
    assign P_O = even_par(sum[7:0]);

endmodule

// File: rtl/cpu_alu_ctrl.sv
// Sequencer around cpu_alu: owns ACC and the C/Z/S/P flags, latches one request,
// holds the ALU inputs for EXEC_CYCLES, then writes back in a single WB cycle.
module cpu_alu_ctrl
    import cpu_alu_pkg::*;
#(
    parameter int         EXEC_CYCLES = 1,
    parameter logic [7:0] ACC_RST     = 8'h00
) (
    input  logic       CLK_I,
    input  logic       RST_N_I,
    input  logic       REQ_I,
    input  logic [2:0] OP_I,
    input  logic [7:0] SRC_I,
    input  logic       ACC_WE_I,
    input  logic [7:0] ACC_D_I,
    output logic       BUSY_O,
    output logic       DONE_O,
    output logic [7:0] ACC_O,
    output logic       FLAG_C_O,
    output logic       FLAG_Z_O,
    output logic       FLAG_S_O,
    output logic       FLAG_P_O
);

    if (EXEC_CYCLES < 1 || EXEC_CYCLES > 15) begin : g_bad_exec_cycles
        $error("cpu_alu_ctrl: EXEC_CYCLES must be in 1..15");
    end

    localparam logic [3:0] CNT_INIT = 4'(EXEC_CYCLES - 1);

    ctrl_state_e state, state_nxt;
    logic [3:0]  cnt;
    logic [7:0]  x_reg, y_reg, acc;
    logic [2:0]  op_reg;
    logic [3:0]  flags;
    logic        done;
    alu_res_t    res;

    logic [7:0]  alu_e;
    logic        alu_c, alu_z, alu_s, alu_p;

    cpu_alu uALU (
        .X_I  (x_reg),
        .Y_I  (y_reg),
        .OP_I (op_reg),
        .C_I  (flags[FLAG_C]),
        .E_O  (alu_e),
        .C_O  (alu_c),
        .Z_O  (alu_z),
        .S_O  (alu_s),
        .P_O  (alu_p)
    );

    always_ff @(posedge CLK_I or negedge RST_N_I) begin
        if (!RST_N_I) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (!ACC_WE_I && REQ_I) state_nxt = EXEC;
            EXEC:    if (cnt == 4'd0) state_nxt = WB;
            WB:      state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // ACC_WE_I wins over REQ_I in IDLE; the request simply stays pending
    always_ff @(posedge CLK_I or negedge RST_N_I) begin
        if (!RST_N_I) begin
            acc    <= ACC_RST;
            flags  <= '0;
            done   <= 1'b0;
            cnt    <= '0;
            x_reg  <= '0;
            y_reg  <= '0;
            op_reg <= ALU_ADD;
            res    <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (ACC_WE_I) begin
                        acc <= ACC_D_I;
                    end else if (REQ_I) begin
                        x_reg  <= acc;
                        y_reg  <= SRC_I;
                        op_reg <= OP_I;
                        cnt    <= CNT_INIT;
                    end
                end
                EXEC: begin
                    if (cnt != 4'd0) cnt <= cnt - 4'd1;
                    else             res <= '{e: alu_e, c: alu_c, z: alu_z, s: alu_s, p: alu_p};
                end
                WB: begin
                    flags[FLAG_C] <= res.c;
                    flags[FLAG_Z] <= res.z;
                    flags[FLAG_S] <= res.s;
                    flags[FLAG_P] <= res.p;
                    if (op_reg != ALU_CMP) acc <= res.e;
                    done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign BUSY_O   = (state != IDLE);
    assign DONE_O   = done;
    assign ACC_O    = acc;
    assign FLAG_C_O = flags[FLAG_C];
    assign FLAG_Z_O = flags[FLAG_Z];
    assign FLAG_S_O = flags[FLAG_S];
    assign FLAG_P_O = flags[FLAG_P];

endmodule

// File: tb/tb_cpu_alu_ctrl.sv
// Directed bench for cpu_alu_ctrl: default instance plus an EXEC_CYCLES=4 instance,
// hand-computed ACC/flag values, latency and BUSY/DONE timing.
module tb_cpu_alu_ctrl;
    import cpu_alu_pkg::*;

    logic       clk, rst_n;
    logic       req, acc_we, busy, done, fc, fz, fs, fp;
    logic [2:0] op;
    logic [7:0] src, acc_d, acc;
    logic       req4, acc_we4, busy4, done4, fc4, fz4, fs4, fp4;
    logic [2:0] op4;
    logic [7:0] src4, acc_d4, acc4;

    int n_chk, n_err;
    int lat, bsy;

    cpu_alu_ctrl dut (
        .CLK_I(clk), .RST_N_I(rst_n), .REQ_I(req), .OP_I(op), .SRC_I(src),
        .ACC_WE_I(acc_we), .ACC_D_I(acc_d), .BUSY_O(busy), .DONE_O(done), .ACC_O(acc),
        .FLAG_C_O(fc), .FLAG_Z_O(fz), .FLAG_S_O(fs), .FLAG_P_O(fp)
    );

    cpu_alu_ctrl #(.EXEC_CYCLES(4), .ACC_RST(8'h00)) dut4 (
        .CLK_I(clk), .RST_N_I(rst_n), .REQ_I(req4), .OP_I(op4), .SRC_I(src4),
        .ACC_WE_I(acc_we4), .ACC_D_I(acc_d4), .BUSY_O(busy4), .DONE_O(done4), .ACC_O(acc4),
        .FLAG_C_O(fc4), .FLAG_Z_O(fz4), .FLAG_S_O(fs4), .FLAG_P_O(fp4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // flags packed as {C,Z,S,P}
    function automatic logic [7:0] flg();
        return 8'({fc, fz, fs, fp});
    endfunction

    // Issue one request; return cycles from accept to DONE and BUSY cycles seen
    task automatic do_op(input logic [2:0] o, input logic [7:0] s, output int l, output int b);
        req = 1'b1; op = o; src = s;
        step();
        req = 1'b0;
        chk("done_fall", 8'(done), 8'h00);
        l = 1; b = 0;
        while (!done && l < 40) begin
            if (busy) b++;
            step();
            l++;
        end
    endtask

    initial begin
        n_chk = 0; n_err = 0;
        rst_n = 1'b0; req = 1'b0; op = ALU_ADD; src = 8'h00; acc_we = 1'b0; acc_d = 8'h00;
        req4 = 1'b0; op4 = ALU_ADD; src4 = 8'h00; acc_we4 = 1'b0; acc_d4 = 8'h00;
        repeat (3) step();
        rst_n = 1'b1;
        step();
        chk("rst_acc", acc, 8'h00);
        chk("rst_flags", flg(), 8'h00);
        chk("rst_busy", 8'(busy), 8'h00);
        chk("rst_done", 8'(done), 8'h00);

        // load then ADD: B3+6C = 11F
        acc_we = 1'b1; acc_d = 8'hB3;
        step();
        acc_we = 1'b0;
        chk("load_acc", acc, 8'hB3);
        do_op(ALU_ADD, 8'h6C, lat, bsy);
        chk("add_lat", 8'(lat), 8'd3);
        chk("add_busy", 8'(bsy), 8'd2);
        chk("add_acc", acc, 8'h1F);
        chk("add_flags", flg(), 8'h08);

        // back-to-back ADC with C=1: 1F+00+1 = 20
        do_op(ALU_ADC, 8'h00, lat, bsy);
        chk("adc_lat", 8'(lat), 8'd3);
        chk("adc_acc", acc, 8'h20);
        chk("adc_flags", flg(), 8'h00);

        // CMP equal: ACC untouched, Z=1 P=1
        do_op(ALU_CMP, 8'h20, lat, bsy);
        chk("cmp_acc", acc, 8'h20);
        chk("cmp_flags", flg(), 8'h05);
        step();
        chk("cmp_done_once", 8'(done), 8'h00);

        // ACC_WE_I beats REQ_I in the same IDLE cycle
        acc_we = 1'b1; acc_d = 8'h55; req = 1'b1; op = ALU_ADD; src = 8'h01;
        step();
        chk("prio_acc", acc, 8'h55);
        chk("prio_busy", 8'(busy), 8'h00);
        acc_we = 1'b0;
        step();
        req = 1'b0;
        chk("prio_accept", 8'(busy), 8'h01);
        // load strobe during EXEC is ignored
        acc_we = 1'b1; acc_d = 8'hAA;
        step();
        acc_we = 1'b0;
        step();
        chk("prio_done", 8'(done), 8'h01);
        chk("prio_acc_res", acc, 8'h56);
        chk("prio_flags", flg(), 8'h01);

        // SUB with borrow: 56-60 = F6, C=1 S=1 P=1
        do_op(ALU_SUB, 8'h60, lat, bsy);
        chk("sub_acc", acc, 8'hF6);
        chk("sub_flags", flg(), 8'h0B);
        // SBB consumes the borrow: F6-00-1 = F5
        do_op(ALU_SBB, 8'h00, lat, bsy);
        chk("sbb_acc", acc, 8'hF5);
        chk("sbb_flags", flg(), 8'h03);
        do_op(ALU_AND, 8'h0F, lat, bsy);
        chk("and_acc", acc, 8'h05);
        chk("and_flags", flg(), 8'h01);
        do_op(ALU_XOR, 8'h05, lat, bsy);
        chk("xor_acc", acc, 8'h00);
        chk("xor_flags", flg(), 8'h05);
        do_op(ALU_OR, 8'h80, lat, bsy);
        chk("or_acc", acc, 8'h80);
        chk("or_flags", flg(), 8'h02);
        step();

        // direct load leaves flags alone
        acc_we = 1'b1; acc_d = 8'h00;
        step();
        acc_we = 1'b0;
        chk("we_acc", acc, 8'h00);
        chk("we_flags", flg(), 8'h02);

        // async reset during EXEC discards the op
        acc_we = 1'b1; acc_d = 8'h10;
        step();
        acc_we = 1'b0; req = 1'b1; op = ALU_ADD; src = 8'h01;
        step();
        req = 1'b0;
        chk("mid_busy", 8'(busy), 8'h01);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", 8'(busy), 8'h00);
        chk("mid_rst_acc", acc, 8'h00);
        chk("mid_rst_flags", flg(), 8'h00);
        #2 rst_n = 1'b1;
        begin
            logic seen;
            seen = 1'b0;
            repeat (4) begin
                step();
                if (done) seen = 1'b1;
            end
            chk("mid_no_done", 8'(seen), 8'h00);
            chk("mid_acc_after", acc, 8'h00);
        end

        // EXEC_CYCLES=4: DONE six cycles after accept, BUSY for five
        req4 = 1'b1; op4 = ALU_ADD; src4 = 8'h07;
        step();
        req4 = 1'b0;
        lat = 1; bsy = 0;
        while (!done4 && lat < 40) begin
            if (busy4) bsy++;
            step();
            lat++;
        end
        chk("e4_lat", 8'(lat), 8'd6);
        chk("e4_busy", 8'(bsy), 8'd5);
        chk("e4_acc", acc4, 8'h07);
        chk("e4_flags", 8'({fc4, fz4, fs4, fp4}), 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/cpu_alu_ctrl.md
Name: cpu_alu_ctrl

Overview:
- Sequencer for the combinational 8008-style cpu_alu. It owns the accumulator and the C/Z/S/P flag register.
- Accepts one ALU operation request at a time and drives the ALU from registered operands.
- Waits a configurable settle time, then writes the result back to the accumulator and updates the flags.
- Sits between the instruction decoder (requester) and cpu_alu inside the CPU core.

Parameters:
- EXEC_CYCLES, 1, cycles the ALU inputs are held before the result is sampled (1..15).
- ACC_RST, 8'h00, accumulator value after reset.

Ports:
- CLK_I  in  1  clock, rising edge.
- RST_N_I  in  1  reset, asynchronous, active-low.
- REQ_I  in  1  operation request; held by the requester until accepted.
- OP_I  in  3  operation code: 000 ADD, 001 ADC, 010 SUB, 011 SBB, 100 AND, 101 XOR, 110 OR, 111 CMP.
- SRC_I  in  8  second operand (ALU Y).
- ACC_WE_I  in  1  direct accumulator load strobe.
- ACC_D_I  in  8  direct accumulator load data.
- BUSY_O  out  1  high whenever state != IDLE; the request is accepted only when low.
- DONE_O  out  1  one-cycle pulse: result and flags are visible.
- ACC_O  out  8  accumulator.
- FLAG_C_O, FLAG_Z_O, FLAG_S_O, FLAG_P_O  out  1 each  flag register (P=1 means even parity).

Behaviour:
- Reset (async, any state):
  - state=IDLE, ACC_O=ACC_RST.
  - All flags 0, DONE_O=0, internal counter 0.
  - An operation in flight is discarded with no DONE_O.
- States: IDLE, EXEC, WB.
- IDLE:
  - ACC_WE_I=1 loads ACC<=ACC_D_I and has priority. A simultaneous REQ_I is not accepted that cycle and stays pending.
  - Else REQ_I=1 is accepted on the edge:
    - X_reg<=ACC, Y_reg<=SRC_I, op_reg<=OP_I.
    - cnt<=EXEC_CYCLES-1, state->EXEC.
- EXEC:
  - cpu_alu is driven with X=X_reg, Y=Y_reg, OP=op_reg, C_I=FLAG_C.
  - cnt!=0: decrement.
  - cnt==0: capture E_O, C_O, Z_O, S_O, P_O into result registers; state->WB.
  - REQ_I and ACC_WE_I are ignored.
- WB, at the edge leaving WB:
  - All four flags <= captured values.
  - ACC<=captured E unless op_reg==CMP (ACC unchanged).
  - DONE_O<=1; state->IDLE.
- DONE_O is registered and high for exactly the one cycle after WB. It falls next edge unconditionally.
- Latency:
  - Request accepted at edge k → DONE_O high in the cycle after edge k+EXEC_CYCLES+1.
  - With the default, 3 cycles per op.
  - Back-to-back: the next request may be accepted at the edge ending the DONE_O cycle.
- Carry chain: ADC/SBB use the flag value from before the current op. Flags are never updated mid-operation.
- Flags change only in WB. ACC_WE_I never alters flags.
- BUSY_O is decoded combinationally from the state register only; there is no input→output combinational path.
- EXEC_CYCLES outside 1..15 is an elaboration error.

Decomposition:
- Shared package cpu_alu_pkg:
  - ALU opcode constants (ALU_ADD … ALU_CMP).
  - Controller state encoding (IDLE=2'd0, EXEC=2'd1, WB=2'd2).
  - Flag bit indices.
- Single sub-module: the existing cpu_alu, instantiated as uALU inside cpu_alu_ctrl. No other hierarchy.

Test Plan:
- Reset: hold RST_N_I=0, then release → ACC_O=8'h00, all flags 0, BUSY_O=0, DONE_O=0.
- Load and ADD:
  - Stimulus: ACC_WE_I with 8'hB3; then REQ_I, OP=ADD, SRC=8'h6C.
  - Response: DONE_O 3 cycles after accept; ACC_O=8'h1F, C=1, Z=0, S=0, P=0. BUSY_O high for exactly 2 cycles.
- ADC with carry-in:
  - Stimulus: following the previous op, OP=ADC, SRC=8'h00.
  - Response: ACC_O=8'h20, C=0, Z=0, S=0, P=0.
- CMP:
  - Stimulus: ACC=8'h20, OP=CMP, SRC=8'h20.
  - Response: ACC_O stays 8'h20, Z=1, C=0, P=1. DONE_O pulses once.
- Priority and ignore rules:
  - ACC_WE_I=1 (8'h55) and REQ_I=1 in the same IDLE cycle → ACC=8'h55, request accepted one cycle later.
  - ACC_WE_I=1 during EXEC → no ACC change.
- Parameter and reset mid-operation:
  - EXEC_CYCLES=4 → DONE_O at accept+6.
  - RST_N_I pulsed low during EXEC → immediate IDLE, ACC_O=ACC_RST, flags 0, no DONE_O pulse.
